// File: rtl/sysbus_mem_responder.sv
// Memory-side Sysbus responder: accepts one 64-byte line request at a time,
// stores write lines from 8 data beats and returns read lines as 8 beats.
module sysbus_mem_responder #(
    parameter int LINES   = 1024,
    parameter int LATENCY = 4,
    parameter int TAG_W   = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reqcyc,
    input  logic [63:0]      req,
    input  logic [TAG_W-1:0] reqtag,
    output logic             reqack,
    output logic             respcyc,
    output logic [63:0]      resp,
    output logic [TAG_W-1:0] resptag,
    input  logic             respack
);

    localparam int IW = $clog2(LINES);
    localparam int AW = IW + 3;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WDATA,
        WAIT,
        RESP
    } state_t;

    state_t           state_reg, state_next;
    logic [2:0]       beat_reg, beat_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             reqack_reg, reqack_next;
    logic             respcyc_reg, respcyc_next;
    logic [IW-1:0]    idx_reg, idx_next;
    logic [TAG_W-1:0] tag_reg, tag_next;

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;

    // Backing store: word address = {line index, beat}; never cleared by reset.
    logic [63:0]      mem_reg [LINES*8];
    logic [63:0]      rdata_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            beat_reg    <= '0;
            cnt_reg     <= '0;
            reqack_reg  <= 1'b0;
            respcyc_reg <= 1'b0;
            idx_reg     <= '0;
            tag_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            beat_reg    <= beat_next;
            cnt_reg     <= cnt_next;
            reqack_reg  <= reqack_next;
            respcyc_reg <= respcyc_next;
            idx_reg     <= idx_next;
            tag_reg     <= tag_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        beat_next    = beat_reg;
        cnt_next     = cnt_reg;
        reqack_next  = 1'b0;
        respcyc_next = respcyc_reg;
        idx_next     = idx_reg;
        tag_next     = tag_reg;
        mem_we       = 1'b0;
        mem_waddr    = {idx_reg, beat_reg};
        rd_en        = 1'b0;
        rd_addr      = {idx_reg, beat_reg};

        case (state_reg)
            IDLE: begin
                if (reqcyc) begin
                    idx_next    = req[6+IW-1:6];
                    tag_next    = reqtag;
                    reqack_next = 1'b1;
                    if (reqtag[TAG_W-1]) begin
                        state_next = WAIT;
                        cnt_next   = CW'(LATENCY - 1);
                    end else begin
                        state_next = WDATA;
                        beat_next  = 3'd0;
                    end
                end
            end
            WDATA: begin
                // A cycle without reqcyc is an initiator stall.
                if (reqcyc) begin
                    mem_we    = 1'b1;
                    beat_next = beat_reg + 3'd1;
                    if (beat_reg == 3'd7) begin
                        state_next = IDLE;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    state_next   = RESP;
                    beat_next    = 3'd0;
                    respcyc_next = 1'b1;
                    rd_en        = 1'b1;
                    rd_addr      = {idx_reg, 3'd0};
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            RESP: begin
                if (respack) begin
                    if (beat_reg != 3'd7) begin
                        beat_next = beat_reg + 3'd1;
                        rd_en     = 1'b1;
                        rd_addr   = {idx_reg, beat_reg + 3'd1};
                    end else begin
                        respcyc_next = 1'b0;
                        state_next   = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_reg[mem_waddr] <= req;
        end
    end

    // Read register only loads when a new beat is presented, so it holds during stalls.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rdata_reg <= mem_reg[rd_addr];
        end
    end

    assign reqack  = reqack_reg;
    assign respcyc = respcyc_reg;
    assign resp    = respcyc_reg ? rdata_reg : 64'd0;
    assign resptag = tag_reg;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(reqack_reg && respcyc_reg));
            assert (!respcyc_reg || state_reg == RESP);
        end
    end
`endif

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Bench for sysbus_mem_responder: directed scenarios plus random line traffic
// checked against a word-addressed reference store.
module tb_sysbus_mem_responder;

    localparam int LINES   = 1024;
    localparam int LATENCY = 4;
    localparam int TAG_W   = 13;

    logic             clk = 1'b0;
    logic             reset;
    logic             reqcyc;
    logic [63:0]      req;
    logic [TAG_W-1:0] reqtag;
    logic             reqack;
    logic             respcyc;
    logic [63:0]      resp;
    logic [TAG_W-1:0] resptag;
    logic             respack;

    int n_assert = 0;
    int n_fail   = 0;

    logic [63:0] ref_mem [int unsigned];
    int unsigned written_lines [$];

    always #5 clk = ~clk;

    sysbus_mem_responder #(
        .LINES  (LINES),
        .LATENCY(LATENCY),
        .TAG_W  (TAG_W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .reqcyc (reqcyc),
        .req    (req),
        .reqtag (reqtag),
        .reqack (reqack),
        .respcyc(respcyc),
        .resp   (resp),
        .resptag(resptag),
        .respack(respack)
    );

    function automatic int unsigned line_of(input logic [63:0] addr);
        return 32'((addr >> 6) % 64'(LINES));
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic issue(input logic [63:0] addr, input logic [TAG_W-1:0] tag);
        int waited;
        waited = 0;
        reqcyc = 1'b1;
        req    = addr;
        reqtag = tag;
        do begin
            @(posedge clk);
            #1;
            waited++;
        end while (!reqack && waited < 64);
        chk("ack_latency", 64'(waited), 64'd1);
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [7:0] id,
                            input logic [7:0][63:0] d, input int stall_beat);
        int unsigned ln;
        ln = line_of(addr);
        issue(addr, {1'b0, 4'b0001, id});
        for (int b = 0; b < 8; b++) begin
            if (b == stall_beat) begin
                reqcyc = 1'b0;
                req    = 64'd0;
                @(posedge clk);
                #1;
                chk("wr_stall_noack", 64'(reqack), 64'd0);
            end
            reqcyc = 1'b1;
            req    = d[b];
            @(posedge clk);
            #1;
            chk("wr_noack", 64'(reqack), 64'd0);
            chk("wr_noresp", 64'(respcyc), 64'd0);
        end
        reqcyc = 1'b0;
        for (int b = 0; b < 8; b++) ref_mem[ln*8 + 32'(b)] = d[b];
        written_lines.push_back(ln);
        $display("WRITE addr=%h line=%0d stall_beat=%0d", addr, ln, stall_beat);
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [7:0] id,
                           input int stall_beat, input int stall_len,
                           input int inject_beat, input logic [63:0] addr2, input logic [7:0] id2,
                           input int reset_beat);
        logic [TAG_W-1:0] tag;
        int unsigned      ln;
        int               lat;
        tag = {1'b1, 4'b0001, id};
        ln  = line_of(addr);
        issue(addr, tag);
        reqcyc = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) chk("ack_one_cycle", 64'(reqack), 64'd0);
        end while (!respcyc && lat < 64);
        chk("first_beat_latency", 64'(lat), 64'(LATENCY));
        respack = 1'b1;
        for (int b = 0; b < 8; b++) begin
            chk("resp_valid", 64'(respcyc), 64'd1);
            chk("resp_data", resp, ref_mem[ln*8 + 32'(b)]);
            chk("resp_tag", 64'(resptag), 64'(tag));
            chk("resp_noack", 64'(reqack), 64'd0);
            if (b == reset_beat) begin
                #2 reset = 1'b1;
                #1;
                chk("reset_respcyc", 64'(respcyc), 64'd0);
                chk("reset_resp", resp, 64'd0);
                chk("reset_resptag", 64'(resptag), 64'd0);
                respack = 1'b0;
                @(posedge clk);
                #1 reset = 1'b0;
                $display("READ addr=%h line=%0d aborted by reset at beat %0d", addr, ln, b);
                return;
            end
            if (b == inject_beat) begin
                reqcyc = 1'b1;
                req    = addr2;
                reqtag = {1'b1, 4'b0001, id2};
            end
            if (b == stall_beat) begin
                respack = 1'b0;
                repeat (stall_len) begin
                    @(posedge clk);
                    #1;
                    chk("stall_valid", 64'(respcyc), 64'd1);
                    chk("stall_hold", resp, ref_mem[ln*8 + 32'(b)]);
                    chk("stall_noack", 64'(reqack), 64'd0);
                end
                respack = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        respack = 1'b0;
        chk("resp_done", 64'(respcyc), 64'd0);
        chk("done_noack", 64'(reqack), 64'd0);
        $display("READ addr=%h line=%0d tag=%h stall_beat=%0d inject_beat=%0d", addr, ln, tag, stall_beat, inject_beat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0][63:0] d;
        logic [63:0]      a;
        int unsigned      ln;
        int               op;

        reset   = 1'b1;
        reqcyc  = 1'b0;
        respack = 1'b0;
        req     = 64'd0;
        reqtag  = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_reqack", 64'(reqack), 64'd0);
        chk("rst_respcyc", 64'(respcyc), 64'd0);
        chk("rst_resp", resp, 64'd0);
        chk("rst_resptag", 64'(resptag), 64'd0);

        // Preload 0x1000 with 0x10..0x17, then read it back back-to-back.
        for (int b = 0; b < 8; b++) d[b] = 64'h10 + 64'(b);
        do_write(64'h1000, 8'h01, d, 8);
        do_read(64'h1000, 8'h11, 8, 0, 8, 64'd0, 8'd0, 8);

        // Write with an initiator stall, then read-after-write.
        for (int b = 0; b < 8; b++) d[b] = 64'hA0 + 64'(b);
        do_write(64'h2040, 8'h02, d, 3);
        do_read(64'h2040, 8'h12, 8, 0, 8, 64'd0, 8'd0, 8);

        // Response stall: word 2 held for 4 cycles total.
        do_read(64'h1000, 8'h13, 2, 3, 8, 64'd0, 8'd0, 8);

        // Second request raised during RESP stays pending until the line completes.
        do_read(64'h2040, 8'h14, 8, 0, 2, 64'h1000, 8'h55, 8);
        do_read(64'h1000, 8'h55, 8, 0, 8, 64'd0, 8'd0, 8);

        // Asynchronous reset on beat 4, then a full re-read of the same line.
        do_read(64'h1000, 8'h16, 8, 0, 8, 64'd0, 8'd0, 4);
        do_read(64'h1000, 8'h17, 8, 0, 8, 64'd0, 8'd0, 8);

        // Aliasing: LINES*64+0x40 maps onto line 1.
        for (int b = 0; b < 8; b++) d[b] = {$urandom, $urandom};
        do_write(64'h40, 8'h03, d, 8);
        do_read(64'(LINES) * 64 + 64'h40, 8'h18, 8, 0, 8, 64'd0, 8'd0, 8);

        // Random traffic; ignored low address bits and alias bits are randomized.
        for (int i = 0; i < 24; i++) begin
            op = int'($urandom_range(0, 2));
            if (op == 0 || written_lines.size() == 0) begin
                ln = $urandom_range(0, LINES - 1);
                for (int b = 0; b < 8; b++) d[b] = {$urandom, $urandom};
                a = 64'(ln) * 64 + 64'($urandom_range(0, 63));
                do_write(a, 8'($urandom), d, int'($urandom_range(0, 8)));
            end else begin
                ln = written_lines[$urandom_range(0, written_lines.size() - 1)];
                a  = (64'(ln) + 64'(LINES) * 64'($urandom_range(0, 3))) * 64 + 64'($urandom_range(0, 63));
                do_read(a, 8'($urandom), int'($urandom_range(0, 8)), int'($urandom_range(1, 3)),
                        8, 64'd0, 8'd0, 8);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
